// File: rtl/instr_encoder_if.sv
// Handshake and instruction-memory write bus of the MIPS-subset instruction encoder.
// The slave side is the encoder; the master side is the stimulus/boot source.
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [3:0]        op_sel_i;
    logic [4:0]        rs_i;
    logic [4:0]        rt_i;
    logic [4:0]        rd_i;
    logic [15:0]       imm_i;
    logic [25:0]       target_i;
    logic              flush_i;
    logic              mem_we_o;
    logic [31:0]       mem_addr_o;
    logic [31:0]       mem_data_o;
    logic [ADDR_W:0]   count_o;
    logic              full_o;
    logic              err_o;

    modport slave (
        input  in_valid_i, op_sel_i, rs_i, rt_i, rd_i, imm_i, target_i, flush_i,
        output in_ready_o, mem_we_o, mem_addr_o, mem_data_o, count_o, full_o, err_o
    );

    modport master (
        output in_valid_i, op_sel_i, rs_i, rt_i, rd_i, imm_i, target_i, flush_i,
        input  in_ready_o, mem_we_o, mem_addr_o, mem_data_o, count_o, full_o, err_o
    );
endinterface

// File: rtl/instr_encoder.sv
// Encodes one symbolic MIPS-subset instruction per handshake into a 32-bit word and
// writes it to instruction memory at an auto-incrementing word address.
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    instr_encoder_if.slave  bus
);
    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

    state_t          state_r;
    logic [ADDR_W:0] wr_ptr_r;
    logic            full_r;
    logic            err_r;
    logic            mem_we_r;
    logic [31:0]     mem_addr_r;
    logic [31:0]     mem_data_r;

    logic            in_ready_s;
    logic            accept_s;
    logic            legal_s;
    logic [31:0]     enc_s;
    logic [ADDR_W:0] ptr_inc_s;
    logic [ADDR_W:0] off_s;
    logic [31:0]     off_ext_s;

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Handshake: ready only out of reset, not flushing and not full.
    always_comb begin
        in_ready_s = rst_i & ~bus.flush_i & ~full_r;
        accept_s   = bus.in_valid_i & in_ready_s;
    end

    // Encode the presented mnemonic; BEQ offset is relative to the slot after this word.
    always_comb begin
        ptr_inc_s = wr_ptr_r + {{ADDR_W{1'b0}}, 1'b1};
        off_s     = {1'b0, bus.target_i[ADDR_W-1:0]} - ptr_inc_s;
        off_ext_s = {{(31-ADDR_W){off_s[ADDR_W]}}, off_s};
        legal_s   = 1'b1;
        enc_s     = 32'h0000_0000;
        case (bus.op_sel_i)
            4'd0:    enc_s = r_type(bus.rs_i, bus.rt_i, bus.rd_i, 6'h20);
            4'd1:    enc_s = r_type(bus.rs_i, bus.rt_i, bus.rd_i, 6'h22);
            4'd2:    enc_s = r_type(bus.rs_i, bus.rt_i, bus.rd_i, 6'h24);
            4'd3:    enc_s = r_type(bus.rs_i, bus.rt_i, bus.rd_i, 6'h25);
            4'd4:    enc_s = r_type(bus.rs_i, bus.rt_i, bus.rd_i, 6'h2A);
            4'd5:    enc_s = r_type(bus.rs_i, 5'd0, 5'd0, 6'h08);
            4'd6:    enc_s = i_type(6'h08, bus.rs_i, bus.rt_i, bus.imm_i);
            4'd7:    enc_s = i_type(6'h0A, bus.rs_i, bus.rt_i, bus.imm_i);
            4'd8:    enc_s = i_type(6'h04, bus.rs_i, bus.rt_i, off_ext_s[15:0]);
            4'd9:    enc_s = i_type(6'h23, bus.rs_i, bus.rt_i, bus.imm_i);
            4'd10:   enc_s = i_type(6'h2B, bus.rs_i, bus.rt_i, bus.imm_i);
            4'd11:   enc_s = {6'h02, bus.target_i};
            4'd12:   enc_s = {6'h03, bus.target_i};
            default: begin
                legal_s = 1'b0;
                enc_s   = 32'h0000_0000;
            end
        endcase
    end

    // Load FSM, write pointer and registered memory-write outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r    <= ST_LOAD;
            wr_ptr_r   <= {(ADDR_W+1){1'b0}};
            full_r     <= 1'b0;
            err_r      <= 1'b0;
            mem_we_r   <= 1'b0;
            mem_addr_r <= 32'h0000_0000;
            mem_data_r <= 32'h0000_0000;
        end else begin
            mem_we_r <= 1'b0;
            if (bus.flush_i) begin
                state_r  <= ST_LOAD;
                wr_ptr_r <= {(ADDR_W+1){1'b0}};
                full_r   <= 1'b0;
            end else begin
                case (state_r)
                    ST_LOAD: begin
                        if (accept_s && legal_s) begin
                            mem_we_r   <= 1'b1;
                            mem_addr_r <= {{(29-ADDR_W){1'b0}}, wr_ptr_r, 2'b00};
                            mem_data_r <= enc_s;
                            wr_ptr_r   <= ptr_inc_s;
                            if (ptr_inc_s == DEPTH_C) begin
                                state_r <= ST_FULL;
                                full_r  <= 1'b1;
                            end
                        end else if (accept_s) begin
                            err_r <= 1'b1;
                        end
                    end
                    ST_FULL: full_r <= 1'b1;
                    default: begin
                        state_r <= ST_LOAD;
                        full_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.in_ready_o = in_ready_s;
    assign bus.mem_we_o   = mem_we_r;
    assign bus.mem_addr_o = mem_addr_r;
    assign bus.mem_data_o = mem_data_r;
    assign bus.count_o    = wr_ptr_r;
    assign bus.full_o     = full_r;
    assign bus.err_o      = err_r;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder: a default-depth instance for encodings and
// error/reset behaviour, and an ADDR_W=2 instance for the full/flush boundary.
module tb_instr_encoder;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    instr_encoder_if #(.ADDR_W(8)) bus8 ();
    instr_encoder_if #(.ADDR_W(2)) bus2 ();

    instr_encoder #(.ADDR_W(8)) u_dut   (.clk_i(clk), .rst_i(rst), .bus(bus8));
    instr_encoder #(.ADDR_W(2)) u_small (.clk_i(clk), .rst_i(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
        bus8.in_valid_i = 1'b1;
        bus8.op_sel_i   = op;
        bus8.rs_i       = rs;
        bus8.rt_i       = rt;
        bus8.rd_i       = rd;
        bus8.imm_i      = imm;
        bus8.target_i   = tgt;
    endtask

    task automatic expect_write8(input string tag, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [31:0] cnt);
        chk({tag, "_we"},    {31'd0, bus8.mem_we_o}, 32'd1);
        chk({tag, "_addr"},  bus8.mem_addr_o, addr);
        chk({tag, "_data"},  bus8.mem_data_o, data);
        chk({tag, "_count"}, {23'd0, bus8.count_o}, cnt);
    endtask

    task automatic flush8();
        bus8.in_valid_i = 1'b0;
        bus8.flush_i    = 1'b1;
        step();
        bus8.flush_i    = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        bus8.in_valid_i = 1'b0; bus8.flush_i = 1'b0; bus8.op_sel_i = 4'd0;
        bus8.rs_i = 5'd0; bus8.rt_i = 5'd0; bus8.rd_i = 5'd0;
        bus8.imm_i = 16'd0; bus8.target_i = 26'd0;
        bus2.in_valid_i = 1'b0; bus2.flush_i = 1'b0; bus2.op_sel_i = 4'd0;
        bus2.rs_i = 5'd0; bus2.rt_i = 5'd0; bus2.rd_i = 5'd0;
        bus2.imm_i = 16'd0; bus2.target_i = 26'd0;

        // Reset state
        step();
        step();
        chk("rst_we",    {31'd0, bus8.mem_we_o}, 32'd0);
        chk("rst_addr",  bus8.mem_addr_o, 32'h0);
        chk("rst_data",  bus8.mem_data_o, 32'h0);
        chk("rst_count", {23'd0, bus8.count_o}, 32'd0);
        chk("rst_full",  {31'd0, bus8.full_o}, 32'd0);
        chk("rst_err",   {31'd0, bus8.err_o}, 32'd0);
        chk("rst_ready", {31'd0, bus8.in_ready_o}, 32'd0);
        rst = 1'b1;
        #1;
        chk("ready_after_rst", {31'd0, bus8.in_ready_o}, 32'd1);

        // Single ADD
        drive8(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        step();
        bus8.in_valid_i = 1'b0;
        expect_write8("add", 32'h0, 32'h0022_1820, 32'd1);
        step();
        chk("idle_we", {31'd0, bus8.mem_we_o}, 32'd0);
        chk("hold_data", bus8.mem_data_o, 32'h0022_1820);

        // Back-to-back ADDI, LW, SW, JR from word 0
        flush8();
        chk("flush_count", {23'd0, bus8.count_o}, 32'd0);
        drive8(4'd6, 5'd0, 5'd8, 5'd0, 16'd5, 26'd0);
        step();
        expect_write8("addi", 32'h0, 32'h2008_0005, 32'd1);
        drive8(4'd9, 5'd29, 5'd4, 5'd0, 16'd8, 26'd0);
        step();
        expect_write8("lw", 32'h4, 32'h8FA4_0008, 32'd2);
        drive8(4'd10, 5'd29, 5'd4, 5'd0, 16'd12, 26'd0);
        step();
        expect_write8("sw", 32'h8, 32'hAFA4_000C, 32'd3);
        drive8(4'd5, 5'd31, 5'd0, 5'd0, 16'd0, 26'd0);
        step();
        expect_write8("jr", 32'hC, 32'h03E0_0008, 32'd4);
        bus8.in_valid_i = 1'b0;

        // Fillers, then BEQ at word 3 targeting word 1, J, JAL, SUB, SLTI
        flush8();
        drive8(4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
        for (int i = 0; i < 3; i++) step();
        expect_write8("filler", 32'h8, 32'h0000_0020, 32'd3);
        drive8(4'd8, 5'd1, 5'd2, 5'd0, 16'd0, 26'd1);
        step();
        expect_write8("beq", 32'hC, 32'h1022_FFFD, 32'd4);
        drive8(4'd11, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10);
        step();
        expect_write8("j", 32'h10, 32'h0800_0010, 32'd5);
        drive8(4'd12, 5'd0, 5'd0, 5'd0, 16'd0, 26'h10);
        step();
        expect_write8("jal", 32'h14, 32'h0C00_0010, 32'd6);
        drive8(4'd1, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        step();
        expect_write8("sub", 32'h18, 32'h0022_1822, 32'd7);
        drive8(4'd7, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'd0);
        step();
        expect_write8("slti", 32'h1C, 32'h2822_FFFF, 32'd8);

        // Illegal op: consumed, no write, sticky error
        drive8(4'd13, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        chk("illegal_ready", {31'd0, bus8.in_ready_o}, 32'd1);
        step();
        chk("illegal_we",    {31'd0, bus8.mem_we_o}, 32'd0);
        chk("illegal_err",   {31'd0, bus8.err_o}, 32'd1);
        chk("illegal_count", {23'd0, bus8.count_o}, 32'd8);
        drive8(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        step();
        expect_write8("post_illegal", 32'h20, 32'h0022_1820, 32'd9);
        flush8();
        chk("err_after_flush", {31'd0, bus8.err_o}, 32'd1);
        chk("count_after_flush", {23'd0, bus8.count_o}, 32'd0);

        // Small instance: fill, hold, flush, restart
        bus2.in_valid_i = 1'b1;
        bus2.op_sel_i = 4'd0; bus2.rs_i = 5'd1; bus2.rt_i = 5'd2; bus2.rd_i = 5'd3;
        for (int i = 0; i < 3; i++) step();
        chk("small_count3", {29'd0, bus2.count_o}, 32'd3);
        chk("small_full3",  {31'd0, bus2.full_o}, 32'd0);
        step();
        chk("small_we4",    {31'd0, bus2.mem_we_o}, 32'd1);
        chk("small_addr4",  bus2.mem_addr_o, 32'hC);
        chk("small_count4", {29'd0, bus2.count_o}, 32'd4);
        chk("small_full4",  {31'd0, bus2.full_o}, 32'd1);
        chk("small_ready4", {31'd0, bus2.in_ready_o}, 32'd0);
        step();
        chk("small_hold_we",    {31'd0, bus2.mem_we_o}, 32'd0);
        chk("small_hold_count", {29'd0, bus2.count_o}, 32'd4);
        bus2.flush_i = 1'b1;
        step();
        chk("small_flush_count", {29'd0, bus2.count_o}, 32'd0);
        chk("small_flush_full",  {31'd0, bus2.full_o}, 32'd0);
        chk("small_flush_we",    {31'd0, bus2.mem_we_o}, 32'd0);
        bus2.flush_i = 1'b0;
        step();
        bus2.in_valid_i = 1'b0;
        chk("small_restart_we",    {31'd0, bus2.mem_we_o}, 32'd1);
        chk("small_restart_addr",  bus2.mem_addr_o, 32'h0);
        chk("small_restart_count", {29'd0, bus2.count_o}, 32'd1);

        // Reset right after an accept, then flush+valid together
        drive8(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        step();
        chk("pre_rst_we", {31'd0, bus8.mem_we_o}, 32'd1);
        bus8.in_valid_i = 1'b0;
        rst = 1'b0;
        #1;
        chk("ready_in_rst", {31'd0, bus8.in_ready_o}, 32'd0);
        step();
        chk("mid_rst_we",    {31'd0, bus8.mem_we_o}, 32'd0);
        chk("mid_rst_addr",  bus8.mem_addr_o, 32'h0);
        chk("mid_rst_data",  bus8.mem_data_o, 32'h0);
        chk("mid_rst_count", {23'd0, bus8.count_o}, 32'd0);
        chk("mid_rst_err",   {31'd0, bus8.err_o}, 32'd0);
        rst = 1'b1;
        bus8.flush_i = 1'b1;
        drive8(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
        #1;
        chk("flush_valid_ready", {31'd0, bus8.in_ready_o}, 32'd0);
        step();
        chk("flush_valid_we",    {31'd0, bus8.mem_we_o}, 32'd0);
        chk("flush_valid_count", {23'd0, bus8.count_o}, 32'd0);
        bus8.flush_i = 1'b0;
        bus8.in_valid_i = 1'b0;
        #1;
        chk("ready_after_flush", {31'd0, bus8.in_ready_o}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
